// File: rtl/bpm_delta_sigma.sv
// Beam position by difference-over-sum on four channel powers.
// Every float operation is sequenced through one shared external float unit.
module bpm_delta_sigma #(
    parameter int unsigned          SF_WIDTH = 32,
    parameter logic [SF_WIDTH-1:0]  KX       = 32'h3F800000,
    parameter logic [SF_WIDTH-1:0]  KY       = 32'h3F800000,
    parameter int unsigned          TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Adj_rdy,
    input  logic [SF_WIDTH-1:0] ChA_Power,
    input  logic [SF_WIDTH-1:0] ChB_Power,
    input  logic [SF_WIDTH-1:0] ChC_Power,
    input  logic [SF_WIDTH-1:0] ChD_Power,
    output logic [SF_WIDTH-1:0] fop_a,
    output logic [SF_WIDTH-1:0] fop_b,
    output logic [1:0]          fop_code,
    output logic                fop_nd,
    input  logic                fop_rfd,
    input  logic [SF_WIDTH-1:0] fop_result,
    input  logic                fop_rdy,
    output logic [SF_WIDTH-1:0] Pos_X,
    output logic [SF_WIDTH-1:0] Pos_Y,
    output logic [SF_WIDTH-1:0] Sum_Out,
    output logic                Pos_rdy,
    output logic                busy,
    output logic [2:0]          err,
    output logic                overrun
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OPC_ADD = 2'd0;
    localparam logic [1:0] OPC_SUB = 2'd1;
    localparam logic [1:0] OPC_DIV = 2'd2;
    localparam logic [1:0] OPC_MUL = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

    typedef enum logic [3:0] {
        OP_SUM_AC, OP_SUB_AC, OP_DIV_X, OP_MUL_X,
        OP_SUM_BD, OP_SUB_BD, OP_DIV_Y, OP_MUL_Y, OP_SUM_ALL
    } op_e;

    state_e state, state_n;
    op_e    op, op_n;

    logic [SF_WIDTH-1:0] lat_a, lat_b, lat_c, lat_d;
    logic [SF_WIDTH-1:0] sum_ac, diff_ac, ratio_x, res_x;
    logic [SF_WIDTH-1:0] sum_bd, diff_bd, ratio_y, res_y;
    logic [SF_WIDTH-1:0] sum_all;
    logic [2:0]          err_acc;
    logic [WD_W-1:0]     wdog;

    logic                accept_c, issue_c, capture_c, abort_c, zero_c;
    logic [SF_WIDTH-1:0] opa_c, opb_c;
    logic [1:0]          opc_c;

    // A new frame is only taken in IDLE, and not in the cycle the previous result is presented
    assign accept_c = Adj_rdy && (state == S_IDLE) && !Pos_rdy;
    assign zero_c   = (fop_result[30:23] == 8'h00);

    // State and op-index register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op    <= OP_SUM_AC;
        end else begin
            state <= state_n;
            op    <= op_n;
        end
    end

    // Next state, op sequencing and operand selection
    always_comb begin
        state_n   = state;
        op_n      = op;
        issue_c   = 1'b0;
        capture_c = 1'b0;
        abort_c   = 1'b0;
        opa_c     = '0;
        opb_c     = '0;
        opc_c     = OPC_ADD;

        unique case (op)
            OP_SUM_AC:  begin opa_c = lat_a;   opb_c = lat_c;  opc_c = OPC_ADD; end
            OP_SUB_AC:  begin opa_c = lat_a;   opb_c = lat_c;  opc_c = OPC_SUB; end
            OP_DIV_X:   begin opa_c = diff_ac; opb_c = sum_ac; opc_c = OPC_DIV; end
            OP_MUL_X:   begin opa_c = ratio_x; opb_c = KX;     opc_c = OPC_MUL; end
            OP_SUM_BD:  begin opa_c = lat_b;   opb_c = lat_d;  opc_c = OPC_ADD; end
            OP_SUB_BD:  begin opa_c = lat_b;   opb_c = lat_d;  opc_c = OPC_SUB; end
            OP_DIV_Y:   begin opa_c = diff_bd; opb_c = sum_bd; opc_c = OPC_DIV; end
            OP_MUL_Y:   begin opa_c = ratio_y; opb_c = KY;     opc_c = OPC_MUL; end
            OP_SUM_ALL: begin opa_c = sum_ac;  opb_c = sum_bd; opc_c = OPC_ADD; end
            default:    ;
        endcase

        unique case (state)
            S_IDLE: begin
                if (accept_c) begin
                    state_n = S_ISSUE;
                    op_n    = OP_SUM_AC;
                end
            end
            S_ISSUE: begin
                if (fop_rfd) begin
                    issue_c = 1'b1;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fop_rdy) begin
                    capture_c = 1'b1;
                    state_n   = S_ISSUE;
                    // Zero/denormal sums skip the rest of that axis
                    if ((op == OP_SUM_AC) && zero_c)
                        op_n = OP_SUM_BD;
                    else if ((op == OP_SUM_BD) && zero_c)
                        op_n = OP_SUM_ALL;
                    else if (op == OP_SUM_ALL)
                        state_n = S_DONE;
                    else
                        op_n = op_e'(4'(op + 4'd1));
                end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    abort_c = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath, float-unit interface and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_a    <= '0;
            lat_b    <= '0;
            lat_c    <= '0;
            lat_d    <= '0;
            sum_ac   <= '0;
            diff_ac  <= '0;
            ratio_x  <= '0;
            res_x    <= '0;
            sum_bd   <= '0;
            diff_bd  <= '0;
            ratio_y  <= '0;
            res_y    <= '0;
            sum_all  <= '0;
            err_acc  <= '0;
            wdog     <= '0;
            fop_a    <= '0;
            fop_b    <= '0;
            fop_code <= '0;
            fop_nd   <= 1'b0;
            Pos_X    <= '0;
            Pos_Y    <= '0;
            Sum_Out  <= '0;
            Pos_rdy  <= 1'b0;
            busy     <= 1'b0;
            err      <= '0;
            overrun  <= 1'b0;
        end else begin
            fop_nd  <= issue_c;
            busy    <= (state_n != S_IDLE);
            Pos_rdy <= (state == S_DONE);

            if (issue_c) begin
                fop_a    <= opa_c;
                fop_b    <= opb_c;
                fop_code <= opc_c;
            end

            if (issue_c)
                wdog <= '0;
            else if (state == S_WAIT)
                wdog <= wdog + WD_W'(1);

            if (Adj_rdy && !accept_c)
                overrun <= 1'b1;

            // Final results start at zero so abandoned ops report 0
            if (accept_c) begin
                lat_a   <= ChA_Power;
                lat_b   <= ChB_Power;
                lat_c   <= ChC_Power;
                lat_d   <= ChD_Power;
                res_x   <= '0;
                res_y   <= '0;
                sum_all <= '0;
                err_acc <= '0;
                err     <= '0;
            end

            if (capture_c) begin
                unique case (op)
                    OP_SUM_AC: begin
                        sum_ac <= fop_result;
                        if (zero_c) err_acc[0] <= 1'b1;
                    end
                    OP_SUB_AC:  diff_ac <= fop_result;
                    OP_DIV_X:   ratio_x <= fop_result;
                    OP_MUL_X:   res_x   <= fop_result;
                    OP_SUM_BD: begin
                        sum_bd <= fop_result;
                        if (zero_c) err_acc[1] <= 1'b1;
                    end
                    OP_SUB_BD:  diff_bd <= fop_result;
                    OP_DIV_Y:   ratio_y <= fop_result;
                    OP_MUL_Y:   res_y   <= fop_result;
                    OP_SUM_ALL: sum_all <= fop_result;
                    default:    ;
                endcase
            end

            if (abort_c)
                err_acc[2] <= 1'b1;

            if (state == S_DONE) begin
                Pos_X   <= res_x;
                Pos_Y   <= res_y;
                Sum_Out <= sum_all;
                err     <= err_acc;
            end
        end
    end

endmodule

// File: tb/tb_bpm_delta_sigma.sv
// Self-checking bench: behavioural float unit plus a difference-over-sum reference
// computed directly from the input powers.
module tb_bpm_delta_sigma;

    logic        clk = 1'b0;
    logic        rst;
    logic        Adj_rdy;
    logic [31:0] ChA_Power, ChB_Power, ChC_Power, ChD_Power;
    logic [31:0] fop_a, fop_b;
    logic [1:0]  fop_code;
    logic        fop_nd;
    logic        fop_rfd = 1'b0;
    logic [31:0] fop_result = '0;
    logic        fop_rdy = 1'b0;
    logic [31:0] Pos_X, Pos_Y, Sum_Out;
    logic        Pos_rdy, busy, overrun;
    logic [2:0]  err;

    bpm_delta_sigma #(.SF_WIDTH(32), .KX(32'h3F800000), .KY(32'h3F800000), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .Adj_rdy(Adj_rdy),
        .ChA_Power(ChA_Power), .ChB_Power(ChB_Power), .ChC_Power(ChC_Power), .ChD_Power(ChD_Power),
        .fop_a(fop_a), .fop_b(fop_b), .fop_code(fop_code), .fop_nd(fop_nd),
        .fop_rfd(fop_rfd), .fop_result(fop_result), .fop_rdy(fop_rdy),
        .Pos_X(Pos_X), .Pos_Y(Pos_Y), .Sum_Out(Sum_Out), .Pos_rdy(Pos_rdy),
        .busy(busy), .err(err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x, y, sum;
        logic [2:0]  err;
        int          nds;
        bit          lat_chk;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        expq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          rfd_q    = 1'b0;
    int          lat      = 4;
    int          rfd_mode = 0;
    int          drop_idx = 0;
    int          nd_cnt   = 0;
    int          last_nd  = 0;
    int          pend     = 0;
    logic [31:0] pend_res = '0;
    logic [31:0] hold_x = '0, hold_y = '0, hold_s = '0;

    localparam logic [31:0] F4 = 32'h40800000, F2 = 32'h40000000, F1 = 32'h3F800000, F0 = 32'h0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // IEEE single <-> real, denormals flushed to zero, round to nearest even
    function automatic real sp2real(input logic [31:0] f);
        if (f[30:23] == 8'h00) return $bitstoreal({f[31], 63'h0});
        if (f[30:23] == 8'hFF) return $bitstoreal({f[31], 11'h7FF, f[22:0], 29'h0});
        return $bitstoreal({f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'h0});
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        int          e;
        logic [30:0] m;
        d = $realtobits(r);
        e = int'(d[62:52]);
        if (e == 2047) return (d[51:0] != 52'h0) ? 32'h7FC00000 : {d[63], 31'h7F800000};
        e = e - 1023 + 127;
        if (e >= 255) return {d[63], 31'h7F800000};
        if (e <= 0) return {d[63], 31'h0};
        m = {8'(e), d[51:29]};
        if (d[28] && ((|d[27:0]) || m[0])) m = m + 31'd1;
        return {d[63], m};
    endfunction

    function automatic logic [31:0] fpu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] code);
        real x, y;
        x = sp2real(a);
        y = sp2real(b);
        case (code)
            2'd0:    return real2sp(x + y);
            2'd1:    return real2sp(x - y);
            2'd2:    return real2sp(x / y);
            default: return real2sp(x * y);
        endcase
    endfunction

    // Counts one float-unit request; the request numbered drop never answers
    function automatic bit issue_ok(inout int n, input int drop, inout bit alive);
        if (!alive) return 1'b0;
        n++;
        if (n == drop) alive = 1'b0;
        return alive;
    endfunction

    function automatic exp_t ref_calc(input logic [31:0] a, b, c, d, input int drop);
        exp_t        e;
        int          n;
        bit          alive;
        logic [31:0] sac, sbd, dx, rx, dy, ry;
        e = '{x: 0, y: 0, sum: 0, err: 0, nds: 0, lat_chk: 0, lat: 0, t0: 0};
        n = 0; alive = 1'b1; sac = 0; sbd = 0; dx = 0; rx = 0; dy = 0; ry = 0;
        if (issue_ok(n, drop, alive)) sac = fpu(a, c, 2'd0);
        if (alive && sac[30:23] == 8'h00) e.err[0] = 1'b1;
        else begin
            if (issue_ok(n, drop, alive)) dx = fpu(a, c, 2'd1);
            if (issue_ok(n, drop, alive)) rx = fpu(dx, sac, 2'd2);
            if (issue_ok(n, drop, alive)) e.x = fpu(rx, 32'h3F800000, 2'd3);
        end
        if (issue_ok(n, drop, alive)) sbd = fpu(b, d, 2'd0);
        if (alive && sbd[30:23] == 8'h00) e.err[1] = 1'b1;
        else begin
            if (issue_ok(n, drop, alive)) dy = fpu(b, d, 2'd1);
            if (issue_ok(n, drop, alive)) ry = fpu(dy, sbd, 2'd2);
            if (issue_ok(n, drop, alive)) e.y = fpu(ry, 32'h3F800000, 2'd3);
        end
        if (issue_ok(n, drop, alive)) e.sum = fpu(sac, sbd, 2'd0);
        if (!alive) e.err[2] = 1'b1;
        e.nds = n;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] x, y, s, input logic [2:0] er, input int nds);
        exp_t e;
        e = '{x: x, y: y, sum: s, err: er, nds: nds, lat_chk: 0, lat: 0, t0: 0};
        return e;
    endfunction

    function automatic logic [31:0] rnd_f();
        logic [31:0] r;
        r = $urandom;
        return {r[31], 8'(120 + ($urandom % 15)), r[22:0]};
    endfunction

    always @(posedge clk) begin
        cyc++;
        rfd_q = fop_rfd;
    end

    // Behavioural float unit: answers L cycles after each request
    always @(negedge clk) begin
        fop_rdy = 1'b0;
        case (rfd_mode)
            0:       fop_rfd = 1'b1;
            1:       fop_rfd = (cyc % 11 == 0);
            default: fop_rfd = ($urandom % 4) != 0;
        endcase
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                fop_rdy    = 1'b1;
                fop_result = pend_res;
            end
        end
        if (fop_nd === 1'b1) begin
            nd_cnt++;
            last_nd = cyc;
            if (nd_cnt != drop_idx) begin
                pend     = lat;
                pend_res = fpu(fop_a, fop_b, fop_code);
            end
        end
    end

    // Output checker against the expectation queue
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (fop_nd === 1'b1 && !rfd_q) chk_int("nd_without_rfd", 1, 0);
            if (Pos_rdy === 1'b1) begin
                if (expq.size() == 0) chk_int("unexpected_pos_rdy", 1, 0);
                else begin
                    e = expq.pop_front();
                    chk32("pos_x", Pos_X, e.x);
                    chk32("pos_y", Pos_Y, e.y);
                    chk32("sum_out", Sum_Out, e.sum);
                    chk32("err", 32'(err), 32'(e.err));
                    chk_int("nd_count", nd_cnt, e.nds);
                    chk_int("rdy_after_last_nd_le_66", int'((cyc - last_nd) <= 66), 1);
                    if (e.lat_chk) begin
                        chk_int("latency_in_tol", int'((cyc - e.t0) >= 9 * (e.lat + 2) + 2 - 9 &&
                                                       (cyc - e.t0) <= 9 * (e.lat + 2) + 2 + 9), 1);
                    end
                    hold_x = e.x;
                    hold_y = e.y;
                    hold_s = e.sum;
                end
            end else begin
                chk32("hold_x", Pos_X, hold_x);
                chk32("hold_y", Pos_Y, hold_y);
                chk32("hold_sum", Sum_Out, hold_s);
            end
        end
    end

    task automatic launch(input logic [31:0] a, b, c, d, input exp_t e);
        @(negedge clk);
        ChA_Power = a; ChB_Power = b; ChC_Power = c; ChD_Power = d;
        Adj_rdy = 1'b1;
        nd_cnt  = 0;
        e.t0    = cyc;
        expq.push_back(e);
        @(negedge clk);
        Adj_rdy = 1'b0;
        ChA_Power = $urandom; ChB_Power = $urandom; ChC_Power = $urandom; ChD_Power = $urandom;
    endtask

    task automatic stray_pulse();
        @(negedge clk);
        ChA_Power = rnd_f(); ChC_Power = rnd_f();
        Adj_rdy = 1'b1;
        @(negedge clk);
        Adj_rdy = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (Pos_rdy !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_int("pos_rdy_arrives", int'(Pos_rdy === 1'b1), 1);
    endtask

    initial begin
        exp_t e, en;
        int   n;
        rst = 1'b1; Adj_rdy = 1'b0;
        ChA_Power = 0; ChB_Power = 0; ChC_Power = 0; ChD_Power = 0;
        repeat (3) @(negedge clk);
        chk32("rst_pos_x", Pos_X, 0);
        chk32("rst_sum", Sum_Out, 0);
        chk_int("rst_flags", int'({Pos_rdy, busy, overrun, fop_nd, err}), 0);
        rst = 1'b0;

        // Model pinned against hand-computed values
        en = ref_calc(F4, F1, F2, F1, 0);
        chk32("model_nom_x", en.x, 32'h3EAAAAAB);
        chk32("model_nom_sum", en.sum, 32'h41000000);
        e = ref_calc(F0, F2, F0, F0, 0);
        chk32("model_zero_y", e.y, 32'h3F800000);
        chk_int("model_zero_nds", e.nds, 6);

        // Nominal
        lat = 4; rfd_mode = 0; drop_idx = 0;
        e = mk(32'h3EAAAAAB, 32'h0, 32'h41000000, 3'b000, 9);
        e.lat_chk = 1'b1; e.lat = 4;
        launch(F4, F1, F2, F1, e);
        wait_done(400);
        repeat (3) @(negedge clk);
        chk_int("busy_idle_after_nominal", int'(busy), 0);

        // Zero X sum
        launch(F0, F2, F0, F0, mk(32'h0, 32'h3F800000, 32'h40000000, 3'b001, 6));
        wait_done(400);
        repeat (3) @(negedge clk);

        // Backpressure
        rfd_mode = 1;
        launch(F4, F1, F2, F1, mk(32'h3EAAAAAB, 32'h0, 32'h41000000, 3'b000, 9));
        wait_done(800);
        repeat (3) @(negedge clk);
        rfd_mode = 0;

        // Timeout on DIV_X
        drop_idx = 3;
        launch(F4, F1, F2, F1, mk(32'h0, 32'h0, 32'h0, 3'b100, 3));
        wait_done(400);
        @(negedge clk);
        chk_int("busy_low_after_timeout", int'(busy), 0);
        drop_idx = 0;
        launch(F4, F1, F2, F1, mk(32'h3EAAAAAB, 32'h0, 32'h41000000, 3'b000, 9));
        wait_done(400);
        repeat (3) @(negedge clk);
        chk_int("no_overrun_yet", int'(overrun), 0);

        // Overrun: second pulse three cycles after the first
        launch(F4, F1, F2, F1, mk(32'h3EAAAAAB, 32'h0, 32'h41000000, 3'b000, 9));
        @(negedge clk);
        stray_pulse();
        wait_done(400);
        repeat (5) @(negedge clk);
        chk_int("overrun_set", int'(overrun), 1);

        // Randomized frames
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b, c, d;
            a = rnd_f(); b = rnd_f(); c = rnd_f(); d = rnd_f();
            case ($urandom % 5)
                1: c = {~a[31], a[30:0]};
                2: d = {~b[31], b[30:0]};
                3: begin a = 0; c = 0; end
                default: ;
            endcase
            lat      = 1 + int'($urandom % 6);
            rfd_mode = 2;
            launch(a, b, c, d, ref_calc(a, b, c, d, 0));
            wait_done(600);
            repeat (2) @(negedge clk);
            chk_int("overrun_sticky", int'(overrun), 1);
        end
        rfd_mode = 0;

        // Reset during MUL_Y WAIT, float unit answers afterwards
        lat = 12;
        launch(F4, F1, F2, F1, mk(32'h3EAAAAAB, 32'h0, 32'h41000000, 3'b000, 9));
        n = 0;
        while (nd_cnt < 8 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk_int("reached_mul_y", nd_cnt, 8);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expq.delete();
        hold_x = 0; hold_y = 0; hold_s = 0;
        chk_int("busy_after_rst", int'(busy), 0);
        chk32("rst_mid_pos_x", Pos_X, 0);
        chk32("rst_mid_sum", Sum_Out, 0);
        chk_int("rst_mid_flags", int'({Pos_rdy, overrun, fop_nd, err}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk_int("overrun_cleared_by_rst", int'(overrun), 0);

        // Recovery, then a request in the result cycle must be refused
        lat = 3;
        launch(F4, F1, F2, F1, mk(32'h3EAAAAAB, 32'h0, 32'h41000000, 3'b000, 9));
        wait_done(400);
        ChA_Power = F1; ChC_Power = F1;
        Adj_rdy = 1'b1;
        @(negedge clk);
        Adj_rdy = 1'b0;
        repeat (80) @(negedge clk);
        chk_int("overrun_on_done_exit", int'(overrun), 1);
        chk_int("busy_final", int'(busy), 0);
        chk_int("queue_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
